// File: rtl/program_loader_if.sv
// Byte-stream and instruction-RAM write bundle for the program loader.
// The master modport is the stream source / RAM side; the slave modport is the loader.
interface program_loader_if #(
    parameter int ADDR_W = 9
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] addr;
    logic              wEn;
    logic [31:0]       wDat;

    modport master (
        output in_valid, in_data,
        input  in_ready, addr, wEn, wDat
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, addr, wEn, wDat
    );
endinterface

// File: rtl/program_loader.sv
// Frames a length-prefixed byte stream into big-endian 32-bit words, writes them to
// instruction RAM from address 0, then releases the core; detects bad lengths and stalls.
module program_loader #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    program_loader_if.slave   bus,
    input  logic              halt,
    input  logic              clear,
    output logic              working,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int WL_W   = ADDR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] TIMEOUT_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0]       DEPTH_MAX    = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_WORD,
        S_WRITE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_len;
    logic [1:0]          r_byte_cnt;
    logic [ADDR_W-1:0]   r_word_idx;
    logic [31:0]         r_asm;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic [WL_W-1:0]     r_words_loaded;

    logic                w_ready_state;
    logic                w_waiting;
    logic                w_accept;
    logic [15:0]         w_len;
    logic                w_len_bad;
    logic                w_last_word;
    logic                w_timeout;

    assign w_ready_state = (r_state == S_IDLE) || (r_state == S_LEN_LO) || (r_state == S_WORD);
    assign w_waiting     = (r_state == S_LEN_LO) || (r_state == S_WORD);
    // Gated by reset so no byte can be handshaken while the block is held in reset.
    assign bus.in_ready  = w_ready_state && reset;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_len         = {r_len[15:8], bus.in_data};
    assign w_len_bad     = (w_len == 16'd0) || ({1'b0, w_len} > DEPTH_MAX);
    assign w_last_word   = (16'(r_word_idx) == (r_len - 16'd1));
    assign w_timeout     = w_waiting && !w_accept && (r_idle_cnt == TIMEOUT_LAST);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_accept)       w_next = w_len_bad ? S_ERROR : S_WORD;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_WORD: begin
                if (w_accept && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
                else if (w_timeout)                   w_next = S_ERROR;
            end
            S_WRITE:  w_next = w_last_word ? S_RUN : S_WORD;
            S_RUN:    if (halt)  w_next = S_IDLE;
            S_ERROR:  if (clear) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_len          <= '0;
            r_byte_cnt     <= '0;
            r_word_idx     <= '0;
            r_asm          <= '0;
            r_idle_cnt     <= '0;
            r_words_loaded <= '0;
        end else begin
            // Stall counter only runs while waiting for a byte and staying put.
            if (w_waiting && !w_accept && (w_next == r_state)) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end else begin
                r_idle_cnt <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_len[15:8]    <= bus.in_data;
                        r_words_loaded <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len      <= w_len;
                        r_byte_cnt <= '0;
                        r_word_idx <= '0;
                    end
                end
                S_WORD: begin
                    if (w_accept) begin
                        r_asm      <= {r_asm[23:0], bus.in_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_words_loaded <= r_words_loaded + WL_W'(1);
                    if (!w_last_word) begin
                        r_word_idx <= r_word_idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wEn     = (r_state == S_WRITE);
    assign bus.addr    = r_word_idx;
    assign bus.wDat    = r_asm;
    assign working     = (r_state == S_RUN);
    assign busy        = w_waiting || (r_state == S_WRITE);
    assign err         = (r_state == S_ERROR);
    assign words_loaded = r_words_loaded;
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder of the processor core's program-load port. It takes a byte stream over a valid/ready interface and frames it into 32-bit big-endian words.
- It drives addr/wEn/wDat to write words into instruction RAM at consecutive word addresses from 0.
- After the last word is written, it asserts working to release the core. It also provides framing-error detection, an inter-byte timeout and a halt/reload path.

Parameters:
- ADDR_W, 9, RAM word-address width; matches the core's addr input.
- DEPTH, 512, maximum program length in words; legal N is 1..DEPTH.
- TIMEOUT_CYC, 1000000, maximum idle cycles between bytes inside a frame before an error is raised.

Ports:
- clock, input, 1, single system clock; all state is updated on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- in_valid, input, 1, byte-stream valid.
- in_data, input, 8, byte-stream data.
- in_ready, output, 1, byte accepted on a cycle where in_valid && in_ready.
- halt, input, 1, synchronous request to stop the core and return to IDLE.
- clear, input, 1, synchronous request to leave ERROR and return to IDLE.
- addr, output, ADDR_W, RAM word address, valid while wEn is high.
- wEn, output, 1, one-cycle RAM write strobe.
- wDat, output, 32, RAM write data.
- working, output, 1, core run enable.
- busy, output, 1, high while a frame is in progress (states LEN_LO, WORD, WRITE).
- err, output, 1, sticky error flag.
- words_loaded, output, ADDR_W+1, count of words written in the current or last frame.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_ready=0 while reset is asserted, addr=0, wEn=0, wDat=0, working=0, busy=0, err=0, words_loaded=0, and all internal counters=0.
- Frame format: LEN_HI, LEN_LO, then N words × 4 bytes, MSB first. N = {LEN_HI, LEN_LO}, 16 bits.
- FSM states: IDLE, LEN_LO, WORD, WRITE, RUN, ERROR.
- IDLE:
  - in_ready=1.
  - An accepted byte is stored as LEN_HI -> LEN_LO.
  - words_loaded is cleared to 0 on that accepted byte.
- LEN_LO:
  - in_ready=1.
  - When a byte is accepted, form N.
  - If N==0 or N>DEPTH -> ERROR.
  - Otherwise -> WORD, with byte_cnt=0 and word_idx=0.
- WORD:
  - in_ready=1.
  - Each accepted byte shifts into a 32-bit assembly register: asm = {asm[23:0], in_data}.
  - byte_cnt increments on each accepted byte.
  - When the 4th byte is accepted -> WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, wEn=1, addr=word_idx[ADDR_W-1:0], wDat=asm.
  - words_loaded increments.
  - If word_idx==N-1 -> RUN. Otherwise word_idx increments and the FSM returns to WORD.
- Write latency: the 4th byte is accepted in cycle t; wEn=1 in cycle t+1. Bytes offered in cycle t+1 are not accepted.
- RUN:
  - working=1 is registered high in the cycle after the final wEn and held.
  - in_ready=0.
  - halt=1 -> IDLE with working=0 on the next cycle. RAM contents are untouched.
- ERROR:
  - err=1, in_ready=0, working=0.
  - clear=1 -> IDLE, err=0.
  - halt is ignored in ERROR.
- Timeout:
  - idle_cnt increments each cycle in LEN_LO or WORD without an accepted byte.
  - idle_cnt resets on an accepted byte or when leaving those states.
  - idle_cnt reaching TIMEOUT_CYC -> ERROR. Words already written remain in RAM, and working stays 0.
- wEn is never asserted outside WRITE. addr wraps are impossible because N ≤ DEPTH.
- Simultaneous events:
  - halt and clear in IDLE, LEN_LO, WORD or WRITE have no effect.
  - Timeout expiry and byte acceptance in the same cycle: the byte wins and the counter resets.
- Reset mid-frame: immediate abort, all outputs return to reset values, and any partial word is discarded.

Test Plan:
- Load N=2 with bytes 00 02 10 0A 00 05 20 A0 00 00, in_valid held high -> wEn pulses at addr 0 with wDat=0x100A0005, then at addr 1 with wDat=0x20A00000. in_ready is low in each WRITE cycle. working=1 one cycle after the 2nd wEn. words_loaded=2.
- Throttled stream with random in_valid gaps (fewer than TIMEOUT_CYC=16 cycles) -> same writes and same data as the previous scenario; no err.
- Length check: N=0x0000 -> err=1 after LEN_LO, no wEn. N=0x0201 with DEPTH=512 -> err=1. Pulse clear -> IDLE, err=0, in_ready=1.
- Timeout with TIMEOUT_CYC=16: N=1, send 2 bytes, then stall 16 cycles -> err=1, wEn never asserted, working=0.
- Halt and reload: after RUN, pulse halt -> working=0 next cycle. Load N=1 word 0x2010_0000 -> single wEn at addr 0; working returns high.
- Reset mid-frame: assert reset after 3 bytes of word 0 -> outputs at reset values immediately. After release, a fresh N=1 load writes the correct word at addr 0.
